// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter with bounded bursts that shares one stream FIFO write port among NUM_REQ requesters.
// The output stage is registered, so there is 1 cycle from handshake to m_valid; backpressure holds the grant without using up the burst.
module stream_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            s_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
  output logic [NUM_REQ-1:0]            s_ready,
  output logic                          m_valid,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic [$clog2(NUM_REQ)-1:0]    m_src,
  input  logic                          m_ready,
  output logic                          busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] rr_ptr, rr_ptr_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic [IW-1:0] idle_cand, cand;
  logic [CW-1:0] beat_cnt, beat_cnt_nxt;
  logic          load_en, any_valid, grant_ok, accept;

  // The +1 wraps explicitly so that non-power-of-2 NUM_REQ never yields an out-of-range index.
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
    return (x == LAST_IDX) ? '0 : x + IW'(1);
  endfunction

  // The loop walks downward so that the requester closest to rr_ptr is written last and wins.
  always_comb begin
    idle_cand = rr_ptr;
    any_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (s_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        idle_cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
        any_valid = 1'b1;
      end
    end
  end

  assign load_en  = !m_valid || m_ready;
  assign cand     = (state == BURST) ? owner : idle_cand;
  assign grant_ok = (state == IDLE) ? any_valid : s_valid[owner];
  assign accept   = grant_ok && load_en && rst_n;
  assign s_ready  = accept ? (NUM_REQ'(1) << cand) : '0;
  assign busy     = (state == BURST);

  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    owner_nxt    = owner;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (MAX_BURST == 1) begin
            rr_ptr_nxt = wrap_inc(cand);
          end else begin
            state_nxt    = BURST;
            owner_nxt    = cand;
            beat_cnt_nxt = CW'(1);
          end
        end
      end
      BURST: begin
        // When the owner drops valid, the grant is released without transferring a beat.
        if (!s_valid[owner]) begin
          state_nxt    = IDLE;
          rr_ptr_nxt   = wrap_inc(owner);
          beat_cnt_nxt = '0;
        end else if (accept) begin
          if (beat_cnt == LAST_BEAT) begin
            state_nxt    = IDLE;
            rr_ptr_nxt   = wrap_inc(owner);
            beat_cnt_nxt = '0;
          end else begin
            beat_cnt_nxt = beat_cnt + CW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      owner    <= owner_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_src   <= '0;
    end else if (load_en) begin
      m_valid <= accept;
      if (accept) begin
        m_data <= s_data[cand*DATA_WIDTH +: DATA_WIDTH];
        m_src  <= cand;
      end
    end
  end
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: requester queues feed the DUT and a transaction model predicts every cycle.
module tb_stream_rr_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NR-1:0] s_valid = '0;
  logic [NR-1:0] s_ready;
  logic [NR*DW-1:0] s_data = '0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [1:0]    m_src;
  logic          m_ready = 1'b1;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Pending beats for each requester; the head of each queue is what that requester presents.
  logic [DW-1:0] qd [NR][1024];
  int hd [NR];
  int tl [NR];

  // Model: holder < 0 means nobody owns the grant.
  int            holder, used, ptr, osrc;
  logic          ov;
  logic [DW-1:0] od;
  logic [15:0]   out_log [$];

  always #5 clk = ~clk;

  stream_rr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_src(m_src), .m_ready(m_ready), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int i, input logic [DW-1:0] v);
    qd[i][tl[i] % 1024] = v;
    tl[i]++;
  endtask

  function automatic bit pending(input int i);
    return tl[i] != hd[i];
  endfunction

  function automatic bit any_pending();
    bit r = 1'b0;
    for (int i = 0; i < NR; i++) if (pending(i)) r = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    holder = -1; used = 0; ptr = 0; ov = 1'b0; od = '0; osrc = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      s_valid[i] = pending(i);
      s_data[i*DW +: DW] = pending(i) ? qd[i][hd[i] % 1024] : '0;
    end
  endtask

  task automatic tick();
    int            cand;
    bit            ld, acc;
    logic [NR-1:0] er;
    drive();
    @(negedge clk);
    ld   = !ov || m_ready;
    cand = -1;
    if (holder < 0) begin
      for (int k = NR - 1; k >= 0; k--) if (pending((ptr + k) % NR)) cand = (ptr + k) % NR;
    end else if (pending(holder)) begin
      cand = holder;
    end
    acc = (cand >= 0) && ld;
    er  = acc ? NR'(1 << cand) : '0;
    chk("s_ready", s_ready, er);
    chk("m_valid", m_valid, ov);
    chk("busy", busy, holder >= 0);
    if (ov) begin
      chk("m_data", m_data, od);
      chk("m_src", m_src, osrc);
    end
    if (m_valid && m_ready) out_log.push_back({6'd0, m_src, m_data});
    if (acc) begin
      ov = 1'b1; od = qd[cand][hd[cand] % 1024]; osrc = cand;
      hd[cand]++;
      used++;
      if (used == MB) begin holder = -1; used = 0; ptr = (cand + 1) % NR; end
      else holder = cand;
    end else begin
      if (ld) ov = 1'b0;
      if (holder >= 0 && !pending(holder)) begin
        ptr = (holder + 1) % NR; holder = -1; used = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((any_pending() || ov) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_done", {31'd0, any_pending() || ov}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NR; i++) begin hd[i] = 0; tl[i] = 0; end
    model_reset();
    #1 rst_n = 1'b0;

    // Reset with every requester valid, followed by continuous round-robin service.
    for (int i = 0; i < NR; i++) for (int k = 0; k < 8; k++) push(i, DW'(i * 16 + k));
    drive();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_src", m_src, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    #1;
    chk("first_grant", s_ready, 4'b0001);
    out_log.delete();
    drain(100);
    chk("rr_count", out_log.size(), 32);
    for (int k = 0; k < 16; k++)
      chk("rr_order", (k < out_log.size()) ? 32'(out_log[k][9:8]) : 32'hdead, (k / 4) % 4);

    // A single requester streams eight beats.
    out_log.delete();
    for (int k = 0; k < 8; k++) push(2, DW'(8'h10 + k));
    drain(30);
    chk("single_count", out_log.size(), 8);
    for (int k = 0; k < 8; k++) begin
      chk("single_data", (k < out_log.size()) ? 32'(out_log[k][7:0]) : 32'hdead, 8'h10 + k);
      chk("single_src", (k < out_log.size()) ? 32'(out_log[k][9:8]) : 32'hdead, 2);
    end

    // Early release: rr_ptr sits at 3, the owner leaves after one beat, and the grant wraps to 0.
    push(3, 8'hA0); push(0, 8'hB0); push(0, 8'hB1); push(0, 8'hB2);
    drive();
    #1;
    chk("er_grant3", s_ready, 4'b1000);
    tick();
    chk("er_busy", busy, 1);
    tick();
    chk("er_idle", busy, 0);
    chk("er_regrant0", s_ready, 4'b0001);
    drain(30);

    // Backpressure after two beats from requester 1.
    for (int k = 0; k < 4; k++) push(1, DW'(8'h30 + k));
    tick();
    tick();
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_data", m_data, 8'h31);
      chk("bp_src", m_src, 1);
      chk("bp_ready", s_ready, 0);
      chk("bp_busy", busy, 1);
    end
    m_ready = 1'b1;
    out_log.delete();
    drain(20);
    chk("bp_count", out_log.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk("bp_tail_data", (k < out_log.size()) ? 32'(out_log[k][7:0]) : 32'hdead, 8'h31 + k);
      chk("bp_tail_src", (k < out_log.size()) ? 32'(out_log[k][9:8]) : 32'hdead, 1);
    end

    // Random traffic with random downstream stalls.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NR; i++)
        if (tl[i] - hd[i] < 6 && $urandom_range(0, 3) == 0) push(i, DW'($urandom_range(0, 255)));
      m_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    m_ready = 1'b1;
    drain(100);

    // Reset arrives in the middle of a burst.
    for (int k = 0; k < 6; k++) push(1, DW'(8'h50 + k));
    tick();
    tick();
    chk("mr_pre_valid", m_valid, 1);
    chk("mr_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_m_valid", m_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_s_ready", s_ready, 0);
    chk("mr_m_data", m_data, 0);
    chk("mr_m_src", m_src, 0);
    model_reset();
    push(0, 8'h60);
    push(3, 8'h70);
    drive();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("mr_regrant0", s_ready, 4'b0001);
    drain(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
